agdc_timed: RTL

- Second-generation automatic garage door controller.
- Drives the up/down motor from an Activate push-button and two limit switches, like the first-generation controller.
- Adds: parametrised travel-timeout watchdog, obstruction auto-reverse, pause-on-activate with direction memory, parametrised auto-close from the fully-open position, and a latched fault state.
- Sits between the debounced door sensors and the motor driver; exposes its state for the status panel.

---
 rtl/agdc_timed_if.sv | 25 ++
 rtl/agdc_timed.sv | 136 +++++++++++++
 2 files changed

// File: rtl/agdc_timed_if.sv
// Sensor/motor bundle between the garage door controller and its surroundings.
// The sensor side (button, limit switches, beam) drives the controller;
// the controller drives the motor commands and status panel.
interface agdc_timed_if;
   logic       Activate;
   logic       UP_Max;
   logic       DN_Max;
   logic       Obstruct;
   logic       UP_M;
   logic       DN_M;
   logic       Fault;
   logic [2:0] State;

   // Environment side: sensors out, motor/status in
   modport master (
      output Activate, UP_Max, DN_Max, Obstruct,
      input  UP_M, DN_M, Fault, State
   );

   // Controller side: sensors in, motor/status out
   modport slave (
      input  Activate, UP_Max, DN_Max, Obstruct,
      output UP_M, DN_M, Fault, State
   );
endinterface

// File: rtl/agdc_timed.sv
// Second-generation garage door controller: motion FSM with travel watchdog,
// obstruction auto-reverse, pause with direction memory, auto-close from the
// fully-open position and a latched fault state.
module agdc_timed #(
   parameter int unsigned TW            = 16,
   parameter int unsigned TIMEOUT_CYC   = 1000,
   parameter int unsigned AUTOCLOSE_CYC = 5000
) (
   input  logic          CLK,
   input  logic          RST,
   agdc_timed_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MV_UP = 3'd1,
      S_MV_DN = 3'd2,
      S_STOP  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   localparam logic          AC_EN   = (AUTOCLOSE_CYC != 0);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
   // With auto-close disabled the compare value is never used.
   localparam logic [TW-1:0] AC_LAST = AC_EN ? TW'(AUTOCLOSE_CYC - 1) : {TW{1'b0}};

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          act_q;
   logic          last_dir_q, last_dir_d;   // 0 = last moved up, 1 = last moved down
   logic          up_m_q, dn_m_q, fault_q;

   logic          act_rise_s;
   logic          both_lim_s;
   logic          ac_count_s;
   logic          timeout_s;
   logic [TW-1:0] timer_inc_s;

   assign act_rise_s  = bus.Activate & ~act_q;
   assign both_lim_s  = bus.UP_Max & bus.DN_Max;
   // Auto-close counts only while parked fully open with a clear beam.
   assign ac_count_s  = AC_EN & bus.UP_Max & ~bus.Obstruct;
   assign timeout_s   = (timer_q == TO_LAST);
   assign timer_inc_s = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + {{(TW-1){1'b0}}, 1'b1};

   // Next-state selection; each state's checks are in priority order.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (both_lim_s)                                      state_d = S_FAULT;
            else if (act_rise_s && bus.DN_Max)                   state_d = S_MV_UP;
            else if (act_rise_s && bus.UP_Max)                   state_d = S_MV_DN;
            else if (act_rise_s)                                 state_d = S_MV_UP;
            else if (ac_count_s && (timer_q == AC_LAST))         state_d = S_MV_DN;
            else                                                 state_d = S_IDLE;
         end
         S_MV_UP: begin
            if (both_lim_s)                                      state_d = S_FAULT;
            else if (bus.UP_Max)                                 state_d = S_IDLE;
            else if (timeout_s)                                  state_d = S_FAULT;
            else if (act_rise_s)                                 state_d = S_STOP;
            else                                                 state_d = S_MV_UP;
         end
         S_MV_DN: begin
            if (both_lim_s)                                      state_d = S_FAULT;
            else if (bus.Obstruct)                               state_d = S_MV_UP;
            else if (bus.DN_Max)                                 state_d = S_IDLE;
            else if (timeout_s)                                  state_d = S_FAULT;
            else if (act_rise_s)                                 state_d = S_STOP;
            else                                                 state_d = S_MV_DN;
         end
         S_STOP: begin
            // Resume opposite to the last travel; never close into an obstruction.
            if (act_rise_s && !last_dir_q && !bus.Obstruct)      state_d = S_MV_DN;
            else if (act_rise_s)                                 state_d = S_MV_UP;
            else if (both_lim_s)                                 state_d = S_FAULT;
            else                                                 state_d = S_STOP;
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FAULT;
      endcase
   end

   // Timer and direction memory next values.
   always_comb begin
      timer_d    = timer_q;
      last_dir_d = last_dir_q;
      if (state_d != state_q) begin
         timer_d = {TW{1'b0}};
      end else if ((state_q == S_MV_UP) || (state_q == S_MV_DN)) begin
         timer_d = timer_inc_s;
      end else if ((state_q == S_IDLE) && ac_count_s) begin
         timer_d = timer_inc_s;
      end else if (state_q == S_IDLE) begin
         timer_d = {TW{1'b0}};
      end else begin
         timer_d = timer_q;
      end

      if ((state_d != state_q) && (state_d == S_MV_UP)) begin
         last_dir_d = 1'b0;
      end else if ((state_d != state_q) && (state_d == S_MV_DN)) begin
         last_dir_d = 1'b1;
      end else begin
         last_dir_d = last_dir_q;
      end
   end

   // State, timer, edge detector and motor/fault outputs, all registered.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= S_IDLE;
         timer_q    <= {TW{1'b0}};
         act_q      <= 1'b0;
         last_dir_q <= 1'b0;
         up_m_q     <= 1'b0;
         dn_m_q     <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         act_q      <= bus.Activate;
         last_dir_q <= last_dir_d;
         up_m_q     <= (state_d == S_MV_UP);
         dn_m_q     <= (state_d == S_MV_DN);
         fault_q    <= (state_d == S_FAULT);
      end
   end

   assign bus.State = state_q;
   assign bus.UP_M  = up_m_q;
   assign bus.DN_M  = dn_m_q;
   assign bus.Fault = fault_q;

endmodule
